// File: rtl/pr_bus_arbiter_pkg.sv
// Shared definitions for the processor-side bus arbiter: FSM states, hit bit
// indices and the address map of the memory region and device windows.
package pr_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int HIT_W    = 7;
  localparam int HIT_MEM  = 0;
  localparam int HIT_DEV0 = 1;
  localparam int NUM_DEV  = 6;

  localparam logic [15:0] MEM_MASK = 16'hE000;
  localparam logic [15:0] MEM_BASE = 16'h0000;
  localparam logic [7:0]  DEV_PAGE = 8'h7F;

  // Inclusive word-aligned offsets inside page 0x7F, element n is device n.
  localparam logic [NUM_DEV-1:0][7:0] DEV_BEGIN_LAST =
    {8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
  localparam logic [NUM_DEV-1:0][7:0] DEV_END_LAST =
    {8'h5F, 8'h4F, 8'h3F, 8'h2F, 8'h1F, 8'h0F};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pr_addr_decode.sv
// Combinational address decoder: 16-bit word address to one-hot
// {dev5..dev0, mem} target select. Address bits [1:0] are ignored.
module pr_addr_decode
  import pr_bus_arbiter_pkg::*;
(
  input  logic [15:0]      addr,
  output logic [HIT_W-1:0] hit
);

  logic [7:0] offset;
  logic [8:0] delta;

  always_comb begin
    hit    = '0;
    delta  = '0;
    offset = {addr[7:2], 2'b00};
    hit[HIT_MEM] = (addr & MEM_MASK) == MEM_BASE;
    // Range test by subtraction so a window starting at 0 needs no special case.
    for (int n = 0; n < NUM_DEV; n++) begin
      delta = {1'b0, offset} - {1'b0, DEV_BEGIN_LAST[n]};
      hit[HIT_DEV0 + n] = (addr[15:8] == DEV_PAGE) && !delta[8] &&
                          (delta[7:0] <= (DEV_END_LAST[n] - DEV_BEGIN_LAST[n]));
    end
  end

endmodule

// File: rtl/pr_bus_arbiter.sv
// Two-master round-robin arbiter and bus sequencer: grants one master, drives
// the device bus, waits for the target's ready and reports unmapped/timeout.
module pr_bus_arbiter
  import pr_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic [15:0]      m0_addr,
  input  logic             m0_we,
  input  logic [3:0]       m0_be,
  input  logic [31:0]      m0_wd,
  output logic             m0_gnt,
  output logic             m0_done,
  output logic             m0_err,
  output logic [31:0]      m0_rd,
  input  logic             m1_req,
  input  logic [15:0]      m1_addr,
  input  logic             m1_we,
  input  logic [3:0]       m1_be,
  input  logic [31:0]      m1_wd,
  output logic             m1_gnt,
  output logic             m1_done,
  output logic             m1_err,
  output logic [31:0]      m1_rd,
  output logic [15:0]      PrAddr,
  output logic [31:0]      PrWD,
  output logic             PrWE,
  output logic [3:0]       PrBE,
  output logic [HIT_W-1:0] PrHIT,
  input  logic [31:0]      PrRD,
  input  logic [HIT_W-1:0] PrReady
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t           state;
  logic             owner;
  logic             last_gnt;
  logic             we_q;
  logic             done_q;
  logic             err_q;
  logic [15:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wd_q;
  logic [31:0]      rd0_q;
  logic [31:0]      rd1_q;
  logic [7:0]       wait_cnt;
  logic [HIT_W-1:0] hit;
  logic             mapped;
  logic             ready;
  logic             first;
  logic             pick;
  logic             ok;

  pr_addr_decode u_decode (
    .addr (addr_q),
    .hit  (hit)
  );

  assign mapped = |hit;
  assign ready  = |(hit & PrReady);
  assign ok     = mapped && ready;
  assign first  = (state == ST_ACCESS) && (wait_cnt == 8'd0);
  // On a tie the master that was not granted last wins.
  assign pick   = (m0_req && m1_req) ? ~last_gnt : m1_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wd_q     <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            owner    <= pick;
            addr_q   <= pick ? {m1_addr[15:2], 2'b00} : {m0_addr[15:2], 2'b00};
            we_q     <= pick ? m1_we : m0_we;
            be_q     <= pick ? m1_be : m0_be;
            wd_q     <= pick ? m1_wd : m0_wd;
            wait_cnt <= '0;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Ready wins over a timeout reached in the same cycle.
          if (!mapped || ready || (wait_cnt == TIMEOUT_CNT)) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            err_q  <= !ok;
            if (owner) rd1_q <= ok ? PrRD : '0;
            else       rd0_q <= ok ? PrRD : '0;
          end else begin
            wait_cnt <= sat_inc8(wait_cnt);
          end
        end
        ST_DONE: begin
          done_q   <= 1'b0;
          err_q    <= 1'b0;
          last_gnt <= owner;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m0_gnt  = (state != ST_IDLE) && !owner;
  assign m1_gnt  = (state != ST_IDLE) && owner;
  assign m0_done = done_q && !owner;
  assign m1_done = done_q && owner;
  assign m0_err  = err_q && !owner;
  assign m1_err  = err_q && owner;
  assign m0_rd   = rd0_q;
  assign m1_rd   = rd1_q;

  assign PrAddr = addr_q;
  assign PrWD   = wd_q;
  assign PrBE   = be_q;
  assign PrHIT  = (state == ST_ACCESS) ? hit : '0;
  assign PrWE   = first && we_q && mapped;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Scoreboard bench for pr_bus_arbiter: directed and random accesses from both
// masters against a transaction-level model of arbitration, decode and timing.
module tb_pr_bus_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wd, m1_wd;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic [15:0] PrAddr;
  logic [31:0] PrWD, PrRD;
  logic        PrWE;
  logic [3:0]  PrBE;
  logic [6:0]  PrHIT, PrReady;

  pr_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rd(m1_rd),
    .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE), .PrBE(PrBE), .PrHIT(PrHIT),
    .PrRD(PrRD), .PrReady(PrReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] rd;
    int          cycles;
    logic [6:0]  hit;
    int          we_n;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] t_addr[2];
  bit          t_we[2];
  logic [3:0]  t_be[2];
  logic [31:0] t_wd[2];
  int          t_dly[2];
  logic [31:0] t_rdata[2];
  bit          t_drop[2];
  int          model_last = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string why);
    n_vec++;
    n_bad++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Target index from the address map: 0 = mem, 1..6 = dev0..dev5, -1 = none.
  function automatic int tgt(input logic [15:0] a);
    logic [15:0] w;
    w = {a[15:2], 2'b00};
    if (w < 16'h2000) return 0;
    if (w >= 16'h7F00 && w <= 16'h7F5F) return 1 + int'((w - 16'h7F00) >> 4);
    return -1;
  endfunction

  function automatic exp_t predict(input int m);
    exp_t e;
    int   t;
    t      = tgt(t_addr[m]);
    e.m    = m;
    e.addr = {t_addr[m][15:2], 2'b00};
    e.wd   = t_wd[m];
    e.be   = t_be[m];
    if (t < 0) begin
      e.hit = '0; e.err = 1'b1; e.rd = '0; e.cycles = 1; e.we_n = 0;
    end else begin
      e.hit  = 7'(1) << t;
      e.we_n = t_we[m] ? 1 : 0;
      if (t_dly[m] <= TMO) begin
        e.err = 1'b0; e.rd = t_rdata[m]; e.cycles = t_dly[m] + 1;
      end else begin
        e.err = 1'b1; e.rd = '0; e.cycles = TMO + 1;
      end
    end
    return e;
  endfunction

  task automatic set_m(input int m, input logic [15:0] a, input bit we, input logic [3:0] be,
                       input logic [31:0] wd, input int dly, input logic [31:0] rdat, input bit drop);
    t_addr[m] = a; t_we[m] = we; t_be[m] = be; t_wd[m] = wd;
    t_dly[m] = dly; t_rdata[m] = rdat; t_drop[m] = drop;
  endtask

  task automatic rand_m(input int m);
    logic [15:0] a;
    case ($urandom_range(0, 3))
      0: a = 16'($urandom_range(0, 16'h1FFF));
      1: a = 16'h7F00 + 16'($urandom_range(0, 5) * 16) + 16'($urandom_range(0, 15));
      2: a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h2000, 16'h7EFF))
                                         : 16'($urandom_range(16'h7F60, 16'hFFFF));
      default: a = 16'($urandom);
    endcase
    set_m(m, a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 7), $urandom,
          $urandom_range(0, 3) == 0);
  endtask

  task automatic run_round(input bit u0, input bit u1);
    bit seen0, seen1;
    int budget;
    int win;
    @(negedge clk);
    seen0 = 1'b0; seen1 = 1'b0;
    if (u0 && u1) begin
      win = model_last ^ 1;
      sb.push_back(predict(win));
      sb.push_back(predict(win ^ 1));
      model_last = win ^ 1;
    end else if (u0) begin
      sb.push_back(predict(0)); model_last = 0;
    end else begin
      sb.push_back(predict(1)); model_last = 1;
    end
    m0_addr = t_addr[0]; m0_we = t_we[0]; m0_be = t_be[0]; m0_wd = t_wd[0];
    m1_addr = t_addr[1]; m1_we = t_we[1]; m1_be = t_be[1]; m1_wd = t_wd[1];
    m0_req = u0; m1_req = u1;
    budget = 0;
    while (((u0 && !seen0) || (u1 && !seen1)) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (m0_done) begin seen0 = 1'b1; m0_req = 1'b0; end
      if (m1_done) begin seen1 = 1'b1; m1_req = 1'b0; end
      if (m0_gnt && t_drop[0]) m0_req = 1'b0;
      if (m1_gnt && t_drop[1]) m1_req = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    if (budget >= 200) flag("round_timeout", "no done within 200 cycles");
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Target emulation: the owning master's target becomes ready after t_dly cycles.
  initial begin
    int         acc;
    int         o;
    logic [6:0] noise;
    acc = 0; PrReady = '0; PrRD = '0;
    forever begin
      @(negedge clk);
      o = m1_gnt ? 1 : 0;
      noise = 7'($urandom);
      if (PrHIT != 0) begin
        PrReady = (noise & ~PrHIT) | ((acc >= t_dly[o]) ? PrHIT : 7'b0);
        PrRD = (acc >= t_dly[o]) ? t_rdata[o] : $urandom;
        acc++;
      end else begin
        acc = 0;
        PrReady = noise;
        PrRD = $urandom;
      end
    end
  end

  // Monitor: checks bus fields at the first ACCESS cycle and the response at done.
  initial begin
    int   cyc, start, wen;
    bit   prev, g;
    exp_t e;
    cyc = 0; start = 0; wen = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev = 1'b0;
      end else begin
        g = m0_gnt | m1_gnt;
        if (g && !prev) begin
          start = cyc; wen = 0;
          if (sb.size() > 0) begin
            e = sb[0];
            chk("gnt_owner", {31'b0, m1_gnt}, e.m);
            chk("PrHIT", {25'b0, PrHIT}, {25'b0, e.hit});
            chk("PrAddr", {16'b0, PrAddr}, {16'b0, e.addr});
            chk("PrBE", {28'b0, PrBE}, {28'b0, e.be});
            chk("PrWD", PrWD, e.wd);
          end
        end
        if (PrWE) wen++;
        if (m0_done || m1_done) begin
          if (sb.size() == 0) begin
            flag("unexpected_done", "done with empty scoreboard");
          end else begin
            e = sb.pop_front();
            chk("done_master", {31'b0, m1_done}, e.m);
            chk("done_excl", {31'b0, m0_done & m1_done}, 0);
            chk("err", {31'b0, (m1_done ? m1_err : m0_err)}, {31'b0, e.err});
            chk("rd", m1_done ? m1_rd : m0_rd, e.rd);
            chk("latency", cyc - start, e.cycles);
            chk("PrWE_count", wen, e.we_n);
          end
        end else if (m0_err || m1_err) begin
          flag("err_without_done", "err high outside done");
        end
        prev = g;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0; m0_we = 0; m1_we = 0;
    m0_be = 0; m1_be = 0; m0_wd = 0; m1_wd = 0;
    for (int m = 0; m < 2; m++) set_m(m, 16'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'b0, m1_gnt, m0_gnt}, 0);
    chk("rst_done", {30'b0, m1_done, m0_done}, 0);
    chk("rst_err", {30'b0, m1_err, m0_err}, 0);
    chk("rst_rd0", m0_rd, 0);
    chk("rst_rd1", m1_rd, 0);
    chk("rst_hit_we", {24'b0, PrHIT, PrWE}, 0);
    chk("rst_bus", {PrAddr, 12'b0, PrBE} | PrWD, 0);
    reset = 1'b0;
    @(negedge clk);

    set_m(0, 16'h0010, 1'b0, 4'hF, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    run_round(1, 0);
    for (int i = 0; i < 4; i++) begin
      rand_m(0); rand_m(1);
      t_drop[0] = 1'b0; t_drop[1] = 1'b0;
      run_round(1, 1);
    end
    set_m(1, 16'h7F04, 1'b1, 4'hF, 32'h12345678, 3, 32'hCAFEF00D, 1'b0);
    run_round(0, 1);
    set_m(0, 16'h5000, 1'b1, 4'h3, 32'hA5A5A5A5, 0, 32'h11111111, 1'b0);
    run_round(1, 0);
    set_m(0, 16'h7F20, 1'b0, 4'hF, 32'h0, 100, 32'h22222222, 1'b0);
    run_round(1, 0);
    set_m(0, 16'h7F20, 1'b0, 4'hF, 32'h0, TMO, 32'h33333333, 1'b0);
    run_round(1, 0);

    for (int i = 0; i < 150; i++) begin
      int k;
      rand_m(0); rand_m(1);
      k = $urandom_range(0, 2);
      run_round(k != 1, k != 0);
    end

    // Reset during a wait: make m0 the last grant, then abort an m1 access.
    set_m(0, 16'h0100, 1'b0, 4'hF, 32'h0, 0, 32'h44444444, 1'b0);
    run_round(1, 0);
    set_m(1, 16'h7F20, 1'b1, 4'hF, 32'h55555555, 100, 32'h66666666, 1'b0);
    @(negedge clk);
    m1_addr = t_addr[1]; m1_we = 1'b1; m1_be = 4'hF; m1_wd = t_wd[1]; m1_req = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_gnt", {30'b0, m1_gnt, m0_gnt}, 0);
    chk("abort_done_err", {28'b0, m1_done, m0_done, m1_err, m0_err}, 0);
    chk("abort_hit_we", {24'b0, PrHIT, PrWE}, 0);
    chk("abort_rd1", m1_rd, 0);
    chk("abort_bus", {PrAddr, 12'b0, PrBE} | PrWD, 0);
    m1_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_last = 1;
    rand_m(0); rand_m(1);
    run_round(1, 1);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
